// File: rtl/params_pkg.sv
// Shared stream parameters, state encoding and last-beat byte-enable helper
// for the AXI4-Stream packet source.
package params_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int KEEP_SHIFT = $clog2(KEEP_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } axis_src_state_e;

    // rem is pkt_len mod KEEP_WIDTH; a zero remainder means the last beat is full
    function automatic logic [KEEP_WIDTH-1:0] last_keep(input logic [KEEP_SHIFT-1:0] rem);
        logic [KEEP_WIDTH-1:0] k;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            k[i] = (rem == '0) || (i < int'(rem));
        end
        return k;
    endfunction

endpackage

// File: rtl/axis_stream_src.sv
// AXI4-Stream packet source: one packet of pkt_len bytes per start, incrementing
// word pattern from seed, partial tkeep and tlast on the final beat, optional idle gaps.
//
// state | meaning
// IDLE  | waiting for start
// SEND  | beat presented (tvalid=1), waiting for tready
// GAP   | idle cycles between beats; also the single busy cycle of a zero-length packet
// DONE  | one-cycle completion pulse
module axis_stream_src
    import params_pkg::*;
#(
    parameter int DATA_WIDTH = params_pkg::DATA_WIDTH,
    parameter int LEN_W      = 23,
    parameter int GAP_W      = 4
) (
    input  logic                    axi_aclk,
    input  logic                    axi_resetn,
    input  logic                    start,
    input  logic [LEN_W-1:0]        pkt_len,
    input  logic [DATA_WIDTH-1:0]   seed,
    input  logic [GAP_W-1:0]        gap,
    output logic                    busy,
    output logic                    done,
    output logic [LEN_W-1:0]        beats_sent,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast
);

    axis_src_state_e state, state_nxt;

    logic [LEN_W-1:0]        beats_left, beats_left_nxt;
    logic [GAP_W-1:0]        gap_cnt, gap_cnt_nxt;
    logic [GAP_W-1:0]        gap_len, gap_len_nxt;
    logic [KEEP_WIDTH-1:0]   keep_last, keep_last_nxt;
    logic [DATA_WIDTH-1:0]   tdata_nxt;
    logic [KEEP_WIDTH-1:0]   tkeep_nxt;
    logic                    tvalid_nxt, tlast_nxt, busy_nxt, done_nxt;
    logic [LEN_W-1:0]        beats_sent_nxt;

    logic [LEN_W:0]          len_round;
    logic [LEN_W-1:0]        beats_calc;
    logic [KEEP_WIDTH-1:0]   keep_calc;

    // Extra bit keeps the ceil() round-up from overflowing near the top of the length range
    assign len_round  = {1'b0, pkt_len} + (LEN_W+1)'(KEEP_WIDTH - 1);
    assign beats_calc = LEN_W'(len_round >> KEEP_SHIFT);
    assign keep_calc  = last_keep(pkt_len[KEEP_SHIFT-1:0]);

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state         <= IDLE;
            beats_left    <= '0;
            gap_cnt       <= '0;
            gap_len       <= '0;
            keep_last     <= '0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            beats_sent    <= '0;
        end else begin
            state         <= state_nxt;
            beats_left    <= beats_left_nxt;
            gap_cnt       <= gap_cnt_nxt;
            gap_len       <= gap_len_nxt;
            keep_last     <= keep_last_nxt;
            m_axis_tdata  <= tdata_nxt;
            m_axis_tkeep  <= tkeep_nxt;
            m_axis_tvalid <= tvalid_nxt;
            m_axis_tlast  <= tlast_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            beats_sent    <= beats_sent_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        beats_left_nxt = beats_left;
        gap_cnt_nxt    = gap_cnt;
        gap_len_nxt    = gap_len;
        keep_last_nxt  = keep_last;
        tdata_nxt      = m_axis_tdata;
        tkeep_nxt      = m_axis_tkeep;
        tvalid_nxt     = m_axis_tvalid;
        tlast_nxt      = m_axis_tlast;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        beats_sent_nxt = beats_sent;

        unique case (state)
            IDLE: begin
                tvalid_nxt = 1'b0;
                tlast_nxt  = 1'b0;
                busy_nxt   = 1'b0;
                if (start) begin
                    busy_nxt       = 1'b1;
                    beats_sent_nxt = '0;
                    gap_len_nxt    = gap;
                    keep_last_nxt  = keep_calc;
                    beats_left_nxt = beats_calc;
                    if (pkt_len != '0) begin
                        state_nxt  = SEND;
                        tdata_nxt  = seed;
                        tvalid_nxt = 1'b1;
                        tlast_nxt  = (beats_calc == LEN_W'(1));
                        tkeep_nxt  = (beats_calc == LEN_W'(1)) ? keep_calc : '1;
                    end else begin
                        // Zero-length: one busy cycle through GAP with nothing left to send
                        state_nxt   = GAP;
                        gap_cnt_nxt = '0;
                    end
                end
            end

            SEND: begin
                if (m_axis_tready) begin
                    beats_sent_nxt = beats_sent + LEN_W'(1);
                    beats_left_nxt = beats_left - LEN_W'(1);
                    if (beats_left == LEN_W'(1)) begin
                        state_nxt  = DONE;
                        tvalid_nxt = 1'b0;
                        tlast_nxt  = 1'b0;
                        busy_nxt   = 1'b0;
                        done_nxt   = 1'b1;
                    end else begin
                        tdata_nxt = m_axis_tdata + DATA_WIDTH'(1);
                        if (gap_len == '0) begin
                            tvalid_nxt = 1'b1;
                            tlast_nxt  = (beats_left == LEN_W'(2));
                            tkeep_nxt  = (beats_left == LEN_W'(2)) ? keep_last : '1;
                        end else begin
                            state_nxt   = GAP;
                            gap_cnt_nxt = gap_len;
                            tvalid_nxt  = 1'b0;
                            tlast_nxt   = 1'b0;
                        end
                    end
                end
            end

            GAP: begin
                if (gap_cnt <= GAP_W'(1)) begin
                    if (beats_left == '0) begin
                        state_nxt = DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt  = SEND;
                        tvalid_nxt = 1'b1;
                        tlast_nxt  = (beats_left == LEN_W'(1));
                        tkeep_nxt  = (beats_left == LEN_W'(1)) ? keep_last : '1;
                    end
                end else begin
                    gap_cnt_nxt = gap_cnt - GAP_W'(1);
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axis_stream_src.sv
// Directed bench for axis_stream_src: hand-computed beats, backpressure, gaps,
// zero-length packets and mid-packet reset.
module tb_axis_stream_src;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [22:0] pkt_len;
    logic [31:0] seed;
    logic [3:0]  gap;
    logic        busy, done;
    logic [22:0] beats_sent;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid, tready, tlast;

    int n_tests = 0;
    int n_fail  = 0;

    axis_stream_src dut (
        .axi_aclk      (clk),
        .axi_resetn    (rst_n),
        .start         (start),
        .pkt_len       (pkt_len),
        .seed          (seed),
        .gap           (gap),
        .busy          (busy),
        .done          (done),
        .beats_sent    (beats_sent),
        .m_axis_tdata  (tdata),
        .m_axis_tkeep  (tkeep),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] d, input logic [3:0] k,
                            input logic l);
        chk({tag, ".tvalid"}, 64'(tvalid), 64'(1));
        chk({tag, ".tdata"},  64'(tdata),  64'(d));
        chk({tag, ".tkeep"},  64'(tkeep),  64'(k));
        chk({tag, ".tlast"},  64'(tlast),  64'(l));
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".busy"},   64'(busy),   64'(0));
        chk({tag, ".done"},   64'(done),   64'(0));
        chk({tag, ".tvalid"}, 64'(tvalid), 64'(0));
        chk({tag, ".tlast"},  64'(tlast),  64'(0));
        chk({tag, ".tdata"},  64'(tdata),  64'(0));
        chk({tag, ".tkeep"},  64'(tkeep),  64'(0));
        chk({tag, ".beats"},  64'(beats_sent), 64'(0));
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        pkt_len = '0;
        seed    = '0;
        gap     = '0;
        tready  = 1'b1;
        repeat (3) tick();
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // len=16, seed 0x100, back-to-back
        pkt_len = 23'd16; seed = 32'h100; gap = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1.busy", 64'(busy), 64'(1));
        chk("t1.beats0", 64'(beats_sent), 64'(0));
        for (int i = 0; i < 4; i++) begin
            chk_beat($sformatf("t1.b%0d", i), 32'h100 + 32'(i), 4'hF, (i == 3));
            tick();
        end
        chk("t1.done", 64'(done), 64'(1));
        chk("t1.busy_off", 64'(busy), 64'(0));
        chk("t1.tvalid_off", 64'(tvalid), 64'(0));
        chk("t1.tlast_off", 64'(tlast), 64'(0));
        chk("t1.beats", 64'(beats_sent), 64'(4));
        tick();
        chk("t1.done_1clk", 64'(done), 64'(0));
        chk("t1.beats_hold", 64'(beats_sent), 64'(4));

        // len=7, data wraps, partial keep
        pkt_len = 23'd7; seed = 32'hFFFF_FFFF; start = 1'b1;
        tick();
        start = 1'b0;
        chk_beat("t2.b0", 32'hFFFF_FFFF, 4'hF, 1'b0);
        tick();
        chk_beat("t2.b1", 32'h0000_0000, 4'h7, 1'b1);
        tick();
        chk("t2.done", 64'(done), 64'(1));
        chk("t2.beats", 64'(beats_sent), 64'(2));
        tick();

        // len=12, backpressure on beat 2
        pkt_len = 23'd12; seed = 32'h10; start = 1'b1;
        tick();
        start = 1'b0;
        chk_beat("t3.b0", 32'h10, 4'hF, 1'b0);
        tick();
        chk_beat("t3.b1", 32'h11, 4'hF, 1'b0);
        tick();
        tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_beat($sformatf("t3.hold%0d", i), 32'h12, 4'hF, 1'b1);
            chk("t3.hold_beats", 64'(beats_sent), 64'(2));
            tick();
        end
        chk_beat("t3.hold_end", 32'h12, 4'hF, 1'b1);
        tready = 1'b1;
        tick();
        chk("t3.done", 64'(done), 64'(1));
        chk("t3.beats", 64'(beats_sent), 64'(3));
        tick();

        // len=8, gap=3, ignored start mid-packet
        pkt_len = 23'd8; seed = 32'h20; gap = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        chk_beat("t4.b0", 32'h20, 4'hF, 1'b0);
        tick();
        chk("t4.gap1", 64'(tvalid), 64'(0));
        chk("t4.gap_busy", 64'(busy), 64'(1));
        pkt_len = 23'd16; seed = 32'hABC; gap = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4.gap2", 64'(tvalid), 64'(0));
        tick();
        chk("t4.gap3", 64'(tvalid), 64'(0));
        tick();
        chk_beat("t4.b1", 32'h21, 4'hF, 1'b1);
        tick();
        chk("t4.done", 64'(done), 64'(1));
        chk("t4.beats", 64'(beats_sent), 64'(2));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t4.no_done%0d", i), 64'(done), 64'(0));
            chk($sformatf("t4.no_valid%0d", i), 64'(tvalid), 64'(0));
            chk($sformatf("t4.no_busy%0d", i), 64'(busy), 64'(0));
        end

        // len=0
        pkt_len = 23'd0; seed = 32'h55; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5.busy", 64'(busy), 64'(1));
        chk("t5.tvalid", 64'(tvalid), 64'(0));
        chk("t5.done_early", 64'(done), 64'(0));
        tick();
        chk("t5.done", 64'(done), 64'(1));
        chk("t5.busy_off", 64'(busy), 64'(0));
        chk("t5.tvalid2", 64'(tvalid), 64'(0));
        chk("t5.beats", 64'(beats_sent), 64'(0));
        tick();
        chk("t5.done_off", 64'(done), 64'(0));

        // len=40, reset during beat 3, then restart
        pkt_len = 23'd40; seed = 32'h500; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk_beat("t6.b3", 32'h503, 4'hF, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("t6.async");
        tick();
        rst_n = 1'b1;
        tick();
        chk_idle_outputs("t6.after");
        pkt_len = 23'd8; seed = 32'h700; start = 1'b1;
        tick();
        start = 1'b0;
        chk_beat("t6.r0", 32'h700, 4'hF, 1'b0);
        chk("t6.r_beats", 64'(beats_sent), 64'(0));
        tick();
        chk_beat("t6.r1", 32'h701, 4'hF, 1'b1);
        tick();
        chk("t6.r_done", 64'(done), 64'(1));
        chk("t6.r_beats2", 64'(beats_sent), 64'(2));
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
